// File: rtl/bitstream_loader_if.sv
// AXI-Stream style interface carrying configuration words to the fabric.
//   tvalid  master -> slave  word valid
//   tdata   master -> slave  DATA_WIDTH-bit configuration word
//   tlast   master -> slave  last word of a CLB frame
//   tready  slave  -> master slave accepts the word this cycle
interface axi_stream_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/bitstream_loader.sv
// Bitstream loader: gathers IN_WIDTH-bit chunks from the configuration pins into
// BITSTREAM_DATA_WIDTH-bit words (LSB slice first) and streams them to the fabric,
// WORDS_PER_CLB words per frame, CLB_COUNT frames per load.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start, abort     begin a full load / abandon the current load
//   in_valid/in_data pin-side chunk, accepted when in_ready is high
//   cfg              one-cycle configuration request pulse
//   cfg_bitstream    word stream to the fabric (tvalid/tdata/tlast out, tready in)
//   cfg_ready        fabric reports all CLBs configured
//   busy, done       load in progress / last load completed (sticky)
module bitstream_loader #(
    parameter int unsigned IN_WIDTH             = 4,
    parameter int unsigned BITSTREAM_DATA_WIDTH = 8,
    parameter int unsigned WORDS_PER_CLB        = 2,
    parameter int unsigned CLB_COUNT            = 36
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                in_valid,
    input  logic [IN_WIDTH-1:0] in_data,
    output logic                in_ready,
    output logic                cfg,
    axi_stream_if.master        cfg_bitstream,
    input  logic                cfg_ready,
    output logic                busy,
    output logic                done
);

    localparam int unsigned CHUNKS  = BITSTREAM_DATA_WIDTH / IN_WIDTH;
    localparam int unsigned CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int unsigned WORD_W  = (WORDS_PER_CLB > 1) ? $clog2(WORDS_PER_CLB) : 1;
    localparam int unsigned FRAME_W = (CLB_COUNT > 1) ? $clog2(CLB_COUNT) : 1;

    localparam logic [CHUNK_W-1:0] ChunkLast = CHUNK_W'(CHUNKS - 1);
    localparam logic [WORD_W-1:0]  WordLast  = WORD_W'(WORDS_PER_CLB - 1);
    localparam logic [FRAME_W-1:0] FrameLast = FRAME_W'(CLB_COUNT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StPack,
        StSend,
        StWaitDone
    } state_e;

    state_e                          state_q;
    logic [CHUNK_W-1:0]              chunk_q;
    logic [WORD_W-1:0]               word_q;
    logic [FRAME_W-1:0]              frame_q;
    logic [BITSTREAM_DATA_WIDTH-1:0] data_q;
    logic                            cfg_q;
    logic                            in_ready_q;
    logic                            tvalid_q;
    logic                            tlast_q;
    logic                            busy_q;
    logic                            done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            chunk_q    <= '0;
            word_q     <= '0;
            frame_q    <= '0;
            data_q     <= '0;
            cfg_q      <= 1'b0;
            in_ready_q <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (abort && (state_q != StIdle)) begin
            // Abort beats any same-cycle chunk or word handshake.
            state_q    <= StIdle;
            chunk_q    <= '0;
            word_q     <= '0;
            frame_q    <= '0;
            data_q     <= '0;
            cfg_q      <= 1'b0;
            in_ready_q <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        state_q <= StReq;
                        chunk_q <= '0;
                        word_q  <= '0;
                        frame_q <= '0;
                        data_q  <= '0;
                        done_q  <= 1'b0;
                        cfg_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StReq: begin
                    state_q    <= StPack;
                    cfg_q      <= 1'b0;
                    in_ready_q <= 1'b1;
                end
                StPack: begin
                    if (in_valid && in_ready_q) begin
                        for (int i = 0; i < int'(CHUNKS); i++) begin
                            if (chunk_q == CHUNK_W'(i)) begin
                                data_q[i*IN_WIDTH +: IN_WIDTH] <= in_data;
                            end
                        end
                        if (chunk_q == ChunkLast) begin
                            chunk_q    <= '0;
                            state_q    <= StSend;
                            in_ready_q <= 1'b0;
                            tvalid_q   <= 1'b1;
                            tlast_q    <= (word_q == WordLast);
                        end else begin
                            chunk_q <= chunk_q + CHUNK_W'(1);
                        end
                    end
                end
                StSend: begin
                    if (cfg_bitstream.tready) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        if ((frame_q == FrameLast) && (word_q == WordLast)) begin
                            state_q <= StWaitDone;
                            word_q  <= '0;
                            frame_q <= '0;
                        end else begin
                            if (word_q == WordLast) begin
                                word_q  <= '0;
                                frame_q <= frame_q + FRAME_W'(1);
                            end else begin
                                word_q <= word_q + WORD_W'(1);
                            end
                            state_q    <= StPack;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                StWaitDone: begin
                    if (cfg_ready) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cfg                  = cfg_q;
    assign in_ready             = in_ready_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign cfg_bitstream.tvalid = tvalid_q;
    assign cfg_bitstream.tlast  = tlast_q;
    assign cfg_bitstream.tdata  = data_q;

endmodule

// File: tb/tb_bitstream_loader.sv
// Testbench for bitstream_loader (defaults, CLB_COUNT = 2): directed scenarios with
// literal expectations, then randomized traffic checked every cycle against a
// transaction-level reference model.
module tb_bitstream_loader;

    localparam int IW = 4;
    localparam int DW = 8;
    localparam int W  = 2;
    localparam int C  = 2;
    localparam int CH = DW / IW;

    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_PACK = 2;
    localparam int M_SEND = 3;
    localparam int M_WAIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic          in_ready;
    logic          cfg;
    logic          cfg_ready = 1'b0;
    logic          busy;
    logic          done;
    logic          tready = 1'b0;

    axi_stream_if #(.DATA_WIDTH(DW)) bs ();
    assign bs.tready = tready;

    bitstream_loader #(
        .IN_WIDTH(IW),
        .BITSTREAM_DATA_WIDTH(DW),
        .WORDS_PER_CLB(W),
        .CLB_COUNT(C)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .cfg(cfg),
        .cfg_bitstream(bs),
        .cfg_ready(cfg_ready),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int hs_cnt = 0;
    logic [8:0] sent[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: load phase plus running chunk/word totals.
    int         m_mode;
    int         m_chunk;
    int         m_words;
    logic [7:0] m_acc;
    logic [7:0] m_tdata;
    logic       m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode  <= M_IDLE;
            m_chunk <= 0;
            m_words <= 0;
            m_acc   <= '0;
            m_tdata <= '0;
            m_done  <= 1'b0;
        end else if (abort && m_mode != M_IDLE) begin
            m_mode  <= M_IDLE;
            m_chunk <= 0;
            m_words <= 0;
            m_acc   <= '0;
        end else begin
            case (m_mode)
                M_IDLE: if (start && !abort) begin
                    m_mode  <= M_REQ;
                    m_chunk <= 0;
                    m_words <= 0;
                    m_acc   <= '0;
                    m_done  <= 1'b0;
                end
                M_REQ: m_mode <= M_PACK;
                M_PACK: if (in_valid) begin
                    if (m_chunk == CH - 1) begin
                        m_tdata <= m_acc + 8'((int'(in_data)) * (1 << (IW * m_chunk)));
                        m_acc   <= '0;
                        m_chunk <= 0;
                        m_mode  <= M_SEND;
                    end else begin
                        m_acc   <= m_acc + 8'((int'(in_data)) * (1 << (IW * m_chunk)));
                        m_chunk <= m_chunk + 1;
                    end
                end
                M_SEND: if (tready) begin
                    m_mode  <= (m_words == W * C - 1) ? M_WAIT : M_PACK;
                    m_words <= m_words + 1;
                end
                M_WAIT: if (cfg_ready) begin
                    m_done <= 1'b1;
                    m_mode <= M_IDLE;
                end
                default: m_mode <= M_IDLE;
            endcase
        end
    end

    // Per-cycle compare plus handshake log.
    always @(negedge clk) begin
        check("cfg", 32'(cfg), 32'(m_mode == M_REQ));
        check("in_ready", 32'(in_ready), 32'(m_mode == M_PACK));
        check("tvalid", 32'(bs.tvalid), 32'(m_mode == M_SEND));
        check("tlast", 32'(bs.tlast), 32'(m_mode == M_SEND && (m_words % W) == W - 1));
        check("busy", 32'(busy), 32'(m_mode != M_IDLE));
        check("done", 32'(done), 32'(m_done));
        if (m_mode == M_SEND) check("tdata", 32'(bs.tdata), 32'(m_tdata));
        if (!rst && bs.tvalid && tready && !abort) begin
            hs_cnt++;
            sent.push_back({bs.tlast, bs.tdata});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Called in PACK: feed one word LSB chunk first, stall tready, then handshake.
    task automatic push_word(input logic [7:0] w, input int stall, input logic exp_last);
        in_valid = 1'b1;
        in_data  = w[3:0];
        tick();
        in_data  = w[7:4];
        tick();
        in_valid = 1'b0;
        tready   = (stall == 0);
        at_neg();
        check("word_tdata", 32'(bs.tdata), 32'(w));
        check("word_tvalid", 32'(bs.tvalid), 32'd1);
        check("word_tlast", 32'(bs.tlast), 32'(exp_last));
        check("word_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            tick();
            if (i == stall - 1) tready = 1'b1;
            at_neg();
            check("held_tdata", 32'(bs.tdata), 32'(w));
            check("held_tlast", 32'(bs.tlast), 32'(exp_last));
            check("held_in_ready", 32'(in_ready), 32'd0);
        end
        tick();
        tready = 1'b0;
    endtask

    task automatic start_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_before;
        repeat (3) @(posedge clk);
        at_neg();
        check("rst_cfg", 32'(cfg), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_tvalid", 32'(bs.tvalid), 32'd0);
        check("rst_tdata", 32'(bs.tdata), 32'd0);
        tick();
        rst = 1'b0;

        // Start handshake: cfg pulse, then PACK.
        start = 1'b1;
        tick();
        start = 1'b0;
        at_neg();
        check("req_cfg", 32'(cfg), 32'd1);
        check("req_busy", 32'(busy), 32'd1);
        check("req_in_ready", 32'(in_ready), 32'd0);
        tick();
        at_neg();
        check("pack_cfg", 32'(cfg), 32'd0);
        check("pack_in_ready", 32'(in_ready), 32'd1);

        // Full load with a 5-cycle stall on the first word.
        sent.delete();
        tick();
        hs_before = hs_cnt;
        push_word(8'hA5, 5, 1'b0);
        check("stall_one_handshake", 32'(hs_cnt - hs_before), 32'd1);
        push_word(8'h3C, 0, 1'b1);
        push_word(8'h01, 0, 1'b0);
        push_word(8'hFF, 2, 1'b1);
        at_neg();
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_tvalid", 32'(bs.tvalid), 32'd0);
        check("wait_in_ready", 32'(in_ready), 32'd0);
        check("sent_count", 32'(sent.size()), 32'd4);
        if (sent.size() == 4) begin
            check("sent0", 32'(sent[0]), 32'h0A5);
            check("sent1", 32'(sent[1]), 32'h13C);
            check("sent2", 32'(sent[2]), 32'h001);
            check("sent3", 32'(sent[3]), 32'h1FF);
        end
        tick();
        tick();
        at_neg();
        check("wait_done_low", 32'(done), 32'd0);
        tick();
        cfg_ready = 1'b1;
        tick();
        cfg_ready = 1'b0;
        at_neg();
        check("done_set", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        at_neg();
        check("done_sticky", 32'(done), 32'd1);

        // abort + start in IDLE: stay idle.
        tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        at_neg();
        check("abort_start_busy", 32'(busy), 32'd0);
        check("abort_start_done", 32'(done), 32'd1);

        // Abort colliding with the first word's handshake.
        tick();
        start_load();
        check("restart_done_clr", 32'(done), 32'd0);
        in_valid = 1'b1;
        in_data  = 4'h1;
        tick();
        in_data  = 4'h0;
        tick();
        in_valid = 1'b0;
        tready   = 1'b1;
        abort    = 1'b1;
        hs_before = hs_cnt;
        tick();
        tready = 1'b0;
        abort  = 1'b0;
        at_neg();
        check("abort_tvalid", 32'(bs.tvalid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_no_hs", 32'(hs_cnt - hs_before), 32'd0);
        tick();
        start_load();
        push_word(8'h77, 0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Reset in PACK after one chunk.
        start_load();
        in_valid = 1'b1;
        in_data  = 4'h9;
        tick();
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_tdata", 32'(bs.tdata), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        at_neg();
        check("post_rst_idle", 32'(busy), 32'd0);
        tick();
        start_load();
        push_word(8'h21, 0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            tick();
            start     = ($urandom_range(0, 7) == 0);
            abort     = ($urandom_range(0, 149) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = IW'($urandom);
            tready    = ($urandom_range(0, 2) != 0);
            cfg_ready = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 499) == 0);
        end
        tick();
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; tready = 1'b0;
        cfg_ready = 1'b0; rst = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
